xor_frame_accumulator: RTL and testbench

Streaming XOR-reduction stage that sits directly downstream of the bitwise `coreir_xor` datapath. It consumes a frame of `width`-bit words over a valid/ready handshake and folds them into a running XOR. On the last word it presents the frame's XOR digest and word count on a registered valid/ready output. Typical use is parity/checksum generation over the per-cycle XOR results of the binary stage.

---
 rtl/xor_frame_acc_pkg.sv | 24 ++
 rtl/coreir_xor.sv | 12 +
 rtl/xor_frame_accumulator.sv | 145 ++++++++++++++
 tb/tb_xor_frame_accumulator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/xor_frame_acc_pkg.sv
// Shared definitions for the XOR frame accumulator: FSM state encoding,
// default parameter values and the saturating counter increment.
package xor_frame_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH     = 1;
  localparam int DEFAULT_CNT_WIDTH = 8;

  // Increment a counter of 'bits' width (1..32), clamping at 2^bits - 1
  // instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned bits);
    logic [32:0] limit;
    logic [32:0] nxt;
    limit = (33'd1 << bits) - 33'd1;
    nxt   = {1'b0, value} + 33'd1;
    return (nxt > limit) ? limit[31:0] : nxt[31:0];
  endfunction

endpackage

// File: rtl/coreir_xor.sv
// Bitwise XOR of two equal-width words; width-preserving.
module coreir_xor #(
  parameter int width = 1
) (
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  output logic [width-1:0] out
);

  assign out = in0 ^ in1;

endmodule

// File: rtl/xor_frame_accumulator.sv
// Streaming XOR-reduction of a frame of words into a registered digest.
// Words arrive on a valid/ready handshake; the word flagged I_last closes
// the frame and the digest plus saturating word count are presented on a
// registered valid/ready output.
// Optional build macro XOR_FRAME_ACC_PIPELINE_EN: while a digest is held,
// input readiness follows O_ready so a new frame can start in the same
// cycle the old digest is consumed (zero-bubble back-to-back frames).
// Without it the stage refuses input while a digest is pending.
// cnt_width is limited to 1..32 by the shared increment helper.
module xor_frame_accumulator
  import xor_frame_acc_pkg::*;
#(
  parameter int width     = DEFAULT_WIDTH,
  parameter int cnt_width = DEFAULT_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [width-1:0]     I,
  input  logic                 I_valid,
  input  logic                 I_last,
  output logic                 I_ready,
  output logic [width-1:0]     O,
  output logic [cnt_width-1:0] O_count,
  output logic                 O_valid,
  input  logic                 O_ready
);

  state_e               state_q, state_d;
  logic [width-1:0]     acc_q, acc_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [width-1:0]     o_q, o_d;
  logic [cnt_width-1:0] o_count_q, o_count_d;
  logic                 o_valid_q, o_valid_d;

  logic [width-1:0]     acc_xor;
  logic [cnt_width-1:0] cnt_inc;
  logic                 accept;
  logic                 consume;

  // Running accumulator folded with the incoming word.
  coreir_xor #(
    .width(width)
  ) u_xor (
    .in0(acc_q),
    .in1(I),
    .out(acc_xor)
  );

  assign cnt_inc = cnt_width'(sat_inc(32'(cnt_q), cnt_width));

  // Readiness depends on state (and O_ready in the pipelined build) only,
  // never on I_valid.
  always_comb begin
    I_ready = 1'b1;
    if (state_q == HOLD) begin
`ifdef XOR_FRAME_ACC_PIPELINE_EN
      I_ready = O_ready;
`else
      I_ready = 1'b0;
`endif
    end
  end

  assign accept  = I_valid && I_ready;
  assign consume = o_valid_q && O_ready;

  // Next-state, accumulator and digest update.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    o_d       = o_q;
    o_count_d = o_count_q;
    o_valid_d = o_valid_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (I_last) begin
            o_d       = acc_xor;
            o_count_d = cnt_inc;
            o_valid_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = HOLD;
          end else begin
            acc_d = acc_xor;
            cnt_d = cnt_inc;
          end
        end
      end

      HOLD: begin
        if (consume) begin
          o_valid_d = 1'b0;
          state_d   = ACCUM;
        end
`ifdef XOR_FRAME_ACC_PIPELINE_EN
        // acc/cnt are zero in HOLD, so the accepted word opens a new frame.
        if (accept) begin
          if (I_last) begin
            o_d       = acc_xor;
            o_count_d = cnt_inc;
            o_valid_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = HOLD;
          end else begin
            acc_d = acc_xor;
            cnt_d = cnt_inc;
          end
        end
`endif
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State registers; reset discards any partial frame and pending digest.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      o_q       <= '0;
      o_count_q <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      o_count_q <= o_count_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign O       = o_q;
  assign O_count = o_count_q;
  assign O_valid = o_valid_q;

endmodule

// File: tb/tb_xor_frame_accumulator.sv
// Bench for xor_frame_accumulator (width=4, cnt_width=3): directed frames
// with literal digests, then randomized traffic against a frame-level model.
module tb_xor_frame_accumulator;

  localparam int W  = 4;
  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

`ifdef XOR_FRAME_ACC_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET;
  logic [W-1:0]  I;
  logic          I_valid;
  logic          I_last;
  logic          I_ready;
  logic [W-1:0]  O;
  logic [CW-1:0] O_count;
  logic          O_valid;
  logic          O_ready;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  xor_frame_accumulator #(.width(W), .cnt_width(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I(I), .I_valid(I_valid), .I_last(I_last), .I_ready(I_ready),
    .O(O), .O_count(O_count), .O_valid(O_valid), .O_ready(O_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: words of the open frame kept in a queue; a closed
  // frame's digest is the XOR of all its words, count = min(len, CNT_MAX).
  logic [W-1:0] frame_q[$];
  logic [W-1:0] m_o;
  int           m_cnt;
  bit           m_valid;

  function automatic bit model_ready();
    return !m_valid || (PIPE && O_ready);
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      frame_q.delete();
      m_o     = '0;
      m_cnt   = 0;
      m_valid = 1'b0;
    end else begin
      bit take;
      take = I_valid && model_ready();
      if (m_valid && O_ready) m_valid = 1'b0;
      if (take) begin
        frame_q.push_back(I);
        if (I_last) begin
          logic [W-1:0] x;
          x = '0;
          foreach (frame_q[k]) x = x ^ frame_q[k];
          m_o     = x;
          m_cnt   = (frame_q.size() > CNT_MAX) ? CNT_MAX : frame_q.size();
          m_valid = 1'b1;
          frame_q.delete();
        end
      end
    end
  end

  // Compare every cycle, mid-period, once reset has been applied.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cmp_o_valid", 32'(O_valid), 32'(m_valid));
      check("cmp_i_ready", 32'(I_ready), 32'(model_ready()));
      check("cmp_o",       32'(O),       32'(m_o));
      check("cmp_o_count", 32'(O_count), 32'(m_cnt));
    end
  end

  // Present one word and hold it until accepted (bounded).
  task automatic send_word(input logic [W-1:0] d, input logic last);
    bit rdy;
    int n;
    I = d; I_valid = 1'b1; I_last = last;
    n = 0;
    do begin
      @(negedge CLK);
      rdy = I_ready;
      @(posedge CLK);
      #1;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) begin
      tests++; fails++;
      $display("FAIL send_timeout actual=not_accepted required=accepted word=%0h", d);
    end
    I_valid = 1'b0; I_last = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; I = '0; I_valid = 1'b0; I_last = 1'b0; O_ready = 1'b1;

    // Reset held two cycles
    @(posedge CLK); #1; chk_en = 1'b1;
    @(posedge CLK); #1; RESET = 1'b0;
    check("rst_o",       32'(O),       32'h0);
    check("rst_o_count", 32'(O_count), 32'h0);
    check("rst_o_valid", 32'(O_valid), 32'h0);
    check("rst_i_ready", 32'(I_ready), 32'h1);

    // 3-word frame, downstream ready
    send_word(4'h3, 1'b0); send_word(4'h5, 1'b0); send_word(4'hA, 1'b1);
    check("f3_o",       32'(O),       32'hC);
    check("f3_o_count", 32'(O_count), 32'd3);
    check("f3_o_valid", 32'(O_valid), 32'h1);
    @(posedge CLK); #1;
    check("f3_o_valid_drop", 32'(O_valid), 32'h0);

    // Backpressure: digest held, input refused, for 4 cycles
    O_ready = 1'b0;
    send_word(4'h3, 1'b0); send_word(4'h5, 1'b0); send_word(4'hA, 1'b1);
    I = 4'h7; I_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("bp_o",       32'(O),       32'hC);
      check("bp_o_count", 32'(O_count), 32'd3);
      check("bp_o_valid", 32'(O_valid), 32'h1);
      check("bp_i_ready", 32'(I_ready), 32'h0);
      @(posedge CLK); #1;
    end
    I_valid = 1'b0; O_ready = 1'b1;
    @(posedge CLK); #1;
    check("bp_consumed", 32'(O_valid), 32'h0);

    // Saturation: nine words of 1
    for (int k = 0; k < 8; k++) send_word(4'h1, 1'b0);
    send_word(4'h1, 1'b1);
    check("sat_o",       32'(O),       32'h1);
    check("sat_o_count", 32'(O_count), 32'd7);
    @(posedge CLK); #1;

    // Reset mid-frame drops the partial accumulation
    send_word(4'hF, 1'b0); send_word(4'h0, 1'b0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    send_word(4'h6, 1'b1);
    check("rmf_o",       32'(O),       32'h6);
    check("rmf_o_count", 32'(O_count), 32'd1);
    @(posedge CLK); #1;

`ifdef XOR_FRAME_ACC_PIPELINE_EN
    // Back-to-back single-word frames with no bubble
    O_ready = 1'b1;
    I = 4'h1; I_valid = 1'b1; I_last = 1'b1;
    @(posedge CLK); #1;
    check("pipe_o1",   32'(O),       32'h1);
    check("pipe_v1",   32'(O_valid), 32'h1);
    check("pipe_rdy1", 32'(I_ready), 32'h1);
    I = 4'h2;
    @(posedge CLK); #1;
    check("pipe_o2",   32'(O),       32'h2);
    check("pipe_v2",   32'(O_valid), 32'h1);
    check("pipe_rdy2", 32'(I_ready), 32'h1);
    I_valid = 1'b0; I_last = 1'b0;
    @(posedge CLK); #1;
    check("pipe_drain", 32'(O_valid), 32'h0);
`endif

    // Randomized traffic with occasional reset
    repeat (600) begin
      I       = W'($urandom_range(0, 15));
      I_valid = ($urandom_range(0, 3) != 0);
      I_last  = ($urandom_range(0, 5) == 0);
      O_ready = ($urandom_range(0, 2) != 0);
      RESET   = ($urandom_range(0, 149) == 0);
      @(posedge CLK); #1;
    end
    RESET = 1'b0; I_valid = 1'b0; I_last = 1'b0; O_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
